// File: rtl/alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler
//   Two requesters share one WIDTH-bit, 8-op ALU through a round-robin
//   arbiter. The winning requester's opcode and operands are captured. The
//   op runs for one cycle. The tagged result is then held on a
//   valid/ready response port until the consumer accepts it.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req0/op0/a0/b0      requester 0 request, opcode and operands
//   ack0                one-cycle pulse when requester 0 operands are captured
//   req1/op1/a1/b1      requester 1 request, opcode and operands
//   ack1                one-cycle pulse when requester 1 operands are captured
//   rsp_valid/rsp_ready response handshake
//   rsp_id              requester that owns the result
//   rsp_data, rsp_err   result; rsp_err flags divide-by-zero
//   busy                high while the scheduler is not idle
//
// Opcodes {c1,c2,c3}: 000 add, 001 sub, 010 mul, 011 div,
//                     100 and, 101 or, 110 xor, 111 not-a
// ---------------------------------------------------------------------------
module alu_rr_scheduler #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] DIV0_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [2:0]       op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             ack0,
    input  logic             req1,
    input  logic [2:0]       op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_reg;
    logic               last_grant_reg;
    logic               id_reg;
    logic [2:0]         op_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;

    logic               winner;
    logic [WIDTH-1:0]   alu_data;
    logic               alu_err;
    logic [2*WIDTH-1:0] prod;

    // On a tie the requester that did not win last time gets the grant;
    // a lone request always wins.
    assign winner = (req0 & req1) ? ~last_grant_reg : req1;

    // ALU on the latched operands; every opcode value is decoded.
    always_comb begin
        alu_data = '0;
        alu_err  = 1'b0;
        prod     = {{WIDTH{1'b0}}, a_reg} * {{WIDTH{1'b0}}, b_reg};
        case (op_reg)
            3'b000: alu_data = a_reg + b_reg;
            3'b001: alu_data = a_reg - b_reg;
            3'b010: alu_data = prod[WIDTH-1:0];
            3'b011: begin
                if (b_reg == '0) begin
                    alu_data = DIV0_VAL;
                    alu_err  = 1'b1;
                end else begin
                    alu_data = a_reg / b_reg;
                end
            end
            3'b100: alu_data = a_reg & b_reg;
            3'b101: alu_data = a_reg | b_reg;
            3'b110: alu_data = a_reg ^ b_reg;
            3'b111: alu_data = ~a_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;  // requester 0 wins the first tie
            id_reg         <= 1'b0;
            op_reg         <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            ack0           <= 1'b0;
            ack1           <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_id         <= 1'b0;
            rsp_data       <= '0;
            rsp_err        <= 1'b0;
            busy           <= 1'b0;
        end else begin
            // Acks are single-cycle pulses raised only on the capture edge.
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req0 | req1) begin
                        op_reg         <= winner ? op1 : op0;
                        a_reg          <= winner ? a1  : a0;
                        b_reg          <= winner ? b1  : b0;
                        id_reg         <= winner;
                        last_grant_reg <= winner;
                        ack0           <= ~winner;
                        ack1           <= winner;
                        busy           <= 1'b1;
                        state_reg      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_data;
                    rsp_err   <= alu_err;
                    rsp_id    <= id_reg;
                    state_reg <= RESP;
                end
                RESP: begin
                    // First RESP cycle raises valid (result is already
                    // stable); afterwards wait for the consumer.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
